// File: rtl/i2s_clk_if.sv
// Control and clock/strobe bundle between i2s_clk_ctrl (master) and the host/codec side (slave).
interface i2s_clk_if #(
  parameter int FRAME_BITS = 64
);
  localparam int BW = $clog2(FRAME_BITS);

  logic          start;
  logic          stop;
  logic          codec_rst_n;
  logic          bclk;
  logic          lrclk;
  logic          en;
  logic          frame_start;
  logic          busy;
  logic [BW-1:0] bit_cnt;

  modport master (
    input  start, stop,
    output codec_rst_n, bclk, lrclk, en, frame_start, busy, bit_cnt
  );

  modport slave (
    output start, stop,
    input  codec_rst_n, bclk, lrclk, en, frame_start, busy, bit_cnt
  );
endinterface

// File: rtl/i2s_clk_ctrl.sv
// I2S master clock sequencer: codec reset, bclk/lrclk generation, warm-up and graceful drain.
// All outputs registered; en strobes with each registered bclk rise while capturing.
module i2s_clk_ctrl #(
  parameter int BCLK_HALF     = 2,
  parameter int FRAME_BITS    = 64,
  parameter int RST_CYCLES    = 16,
  parameter int WARMUP_FRAMES = 2
) (
  input logic       clk,
  input logic       rst,
  i2s_clk_if.master bus
);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int DW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int WW = $clog2(WARMUP_FRAMES + 1);

  typedef enum logic [2:0] {IDLE, CODEC_RST, WARMUP, RUN, DRAIN} state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [RW-1:0] rst_cnt;
  logic [WW-1:0] wu_cnt;
  logic          codec_rst_n;
  logic          bclk;
  logic          lrclk;
  logic          en;
  logic          frame_start;
  logic          busy;
  logic [BW-1:0] bit_cnt;

  logic          div_tc;
  logic          frame_end;
  logic [BW-1:0] bit_nxt;

  assign div_tc    = (div == DW'(BCLK_HALF - 1));
  assign bit_nxt   = bit_cnt + BW'(1);
  // Frame ends on the falling toggle that leaves the last bit of the frame.
  assign frame_end = div_tc && bclk && (&bit_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      div         <= '0;
      rst_cnt     <= '0;
      wu_cnt      <= '0;
      codec_rst_n <= 1'b0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      en          <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      en          <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state   <= CODEC_RST;
            busy    <= 1'b1;
            rst_cnt <= '0;
            wu_cnt  <= '0;
          end
        end
        CODEC_RST: begin
          if (bus.stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rst_cnt == RW'(RST_CYCLES - 1)) begin
            codec_rst_n <= 1'b1;
            state       <= WARMUP;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        WARMUP, RUN, DRAIN: begin
          if (state == WARMUP && bus.stop) begin
            // Abandon the partial frame and return straight to idle levels.
            state       <= IDLE;
            busy        <= 1'b0;
            codec_rst_n <= 1'b0;
            bclk        <= 1'b0;
            lrclk       <= 1'b0;
            bit_cnt     <= '0;
            div         <= '0;
          end else begin
            if (state == RUN && bus.stop) state <= DRAIN;
            if (!div_tc) begin
              div <= div + DW'(1);
            end else begin
              div  <= '0;
              bclk <= ~bclk;
              if (!bclk) begin
                en <= (state != WARMUP);
              end else begin
                bit_cnt <= bit_nxt;
                lrclk   <= bit_nxt[BW-1];
              end
            end
            if (frame_end) begin
              frame_start <= (state != WARMUP);
              if (state == WARMUP) begin
                if (wu_cnt == WW'(WARMUP_FRAMES - 1)) state <= RUN;
                else wu_cnt <= wu_cnt + WW'(1);
              end else if (state == DRAIN) begin
                // bclk falls on this same edge, so clocks park low from here.
                state       <= IDLE;
                busy        <= 1'b0;
                codec_rst_n <= 1'b0;
                lrclk       <= 1'b0;
                div         <= '0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.codec_rst_n = codec_rst_n;
  assign bus.bclk        = bclk;
  assign bus.lrclk       = lrclk;
  assign bus.en          = en;
  assign bus.frame_start = frame_start;
  assign bus.busy        = busy;
  assign bus.bit_cnt     = bit_cnt;
endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// Directed bench for i2s_clk_ctrl at default parameters; event timings are scoreboarded by clk index.
module tb_i2s_clk_ctrl;
  localparam int EV_RSTN  = 0;
  localparam int EV_BRISE = 1;
  localparam int EV_EN    = 2;
  localparam int EV_FS    = 3;
  localparam int EV_BFALL = 4;

  typedef struct {
    int    kind;
    int    cyc;
    string tag;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;

  i2s_clk_if #(.FRAME_BITS(64)) bus();

  i2s_clk_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0, n_fail = 0;
  int   n_en, n_fs, n_brise, n_bhigh, n_lrlow, n_badper, n_lrbad, n_rstnhi, last_rise;
  int   p_bclk, p_lr, p_rstn, p_busy, p_bit;
  int   hits;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int kind, input int c, input string tag);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic clr();
    n_en = 0; n_fs = 0; n_brise = 0; n_bhigh = 0; n_lrlow = 0;
    n_badper = 0; n_lrbad = 0; n_rstnhi = 0; last_rise = -1;
  endtask

  // Advance to the next falling clk edge and fold the observed outputs into the counters.
  task automatic step();
    p_bclk = int'(bus.bclk);
    p_lr   = int'(bus.lrclk);
    p_rstn = int'(bus.codec_rst_n);
    p_busy = int'(bus.busy);
    p_bit  = int'(bus.bit_cnt);
    @(negedge clk);
    hits = 0;
    if (bus.codec_rst_n && p_rstn == 0) hits[EV_RSTN] = 1'b1;
    if (bus.en) begin
      hits[EV_EN] = 1'b1;
      n_en++;
    end
    if (bus.frame_start) begin
      hits[EV_FS] = 1'b1;
      n_fs++;
    end
    if (!bus.busy && p_busy == 1) hits[EV_BFALL] = 1'b1;
    if (bus.bclk && p_bclk == 0) begin
      hits[EV_BRISE] = 1'b1;
      n_brise++;
      if (last_rise >= 0 && cyc - last_rise != 4) n_badper++;
      last_rise = cyc;
    end
    if (bus.bclk) n_bhigh++;
    if (!bus.lrclk) n_lrlow++;
    if (int'(bus.lrclk) != p_lr && !(p_bclk == 1 && !bus.bclk)) n_lrbad++;
    if (bus.lrclk !== (bus.bit_cnt >= 6'd32)) n_lrbad++;
    if (bus.codec_rst_n) n_rstnhi++;
  endtask

  task automatic wait_evt(input int kind, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (hits[kind]) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic drain_sb(input int bound);
    exp_t e;
    int   at;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_evt(e.kind, bound, at);
      check(e.tag, at, e.cyc);
    end
  endtask

  // Start pulse sampled at edge k: codec_rst_n up at k+16, bclk up at k+18, first en at k+530.
  task automatic start_seq(input string pfx);
    int k;
    clr();
    k = cyc + 1;
    bus.start = 1'b1;
    push(EV_RSTN,  k + 16,  {pfx, "_rstn_rise"});
    push(EV_BRISE, k + 18,  {pfx, "_first_bclk_rise"});
    push(EV_EN,    k + 530, {pfx, "_first_en"});
    step();
    bus.start = 1'b0;
    check({pfx, "_busy_k1"}, int'(bus.busy), 1);
    check({pfx, "_rstn_low_k1"}, int'(bus.codec_rst_n), 0);
    drain_sb(700);
    check({pfx, "_en_count_at_first"}, n_en, 1);
  endtask

  initial begin
    int f, e, k;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({bus.codec_rst_n, bus.bclk, bus.lrclk, bus.en,
                                 bus.frame_start, bus.busy, bus.bit_cnt}), 0);
    rst = 1'b0;
    step();
    check("post_reset_busy", int'(bus.busy), 0);

    // Power-up timing.
    start_seq("s1");

    // One full RUN frame aligned on frame_start.
    wait_evt(EV_FS, 300, f);
    check("fs_found", int'(f > 0), 1);
    clr();
    push(EV_FS, f + 256, "frame_period");
    drain_sb(300);
    check("en_per_frame", n_en, 64);
    check("fs_per_frame", n_fs, 1);
    check("bclk_rises_per_frame", n_brise, 64);
    check("bclk_high_clks", n_bhigh, 128);
    check("lrclk_low_clks", n_lrlow, 128);
    check("lrclk_align", n_lrbad, 0);

    // Second start during RUN must not disturb anything.
    repeat (50) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    push(EV_FS, f + 512, "frame_period_after_start");
    drain_sb(300);
    check("busy_after_restart_req", int'(bus.busy), 1);
    check("bclk_period_glitch", n_badper, 0);
    check("en_two_frames", n_en, 128);
    check("fs_two_frames", n_fs, 2);

    // Stop at bit 40: drain completes the frame.
    e = -1;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.bit_cnt == 6'd40 && p_bit == 39) begin
        e = cyc;
        break;
      end
    end
    check("find_bit40", int'(e > 0), 1);
    clr();
    bus.stop = 1'b1;
    push(EV_BFALL, e + 96, "drain_to_idle");
    step();
    bus.stop = 1'b0;
    drain_sb(200);
    check("drain_en_count", n_en, 24);
    check("drain_lrclk_align", n_lrbad, 0);
    check("idle_bclk", int'(bus.bclk), 0);
    check("idle_lrclk", int'(bus.lrclk), 0);
    check("idle_rstn", int'(bus.codec_rst_n), 0);
    check("idle_bitcnt", int'(bus.bit_cnt), 0);
    clr();
    repeat (40) step();
    check("idle_no_bclk", n_brise, 0);
    check("idle_no_en", n_en, 0);

    // Stop during CODEC_RST at k+5.
    clr();
    k = cyc + 1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    while (cyc < k + 4) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("crst_stop_cyc", cyc, k + 5);
    check("crst_stop_busy", int'(bus.busy), 0);
    check("crst_stop_rstn", int'(bus.codec_rst_n), 0);
    repeat (600) step();
    check("crst_stop_no_en", n_en, 0);
    check("crst_stop_rstn_never", n_rstnhi, 0);
    check("crst_stop_no_bclk", n_brise, 0);

    // Stop during WARMUP.
    clr();
    k = cyc + 1;
    bus.start = 1'b1;
    push(EV_BRISE, k + 18, "wu_first_bclk_rise");
    step();
    bus.start = 1'b0;
    drain_sb(100);
    repeat (60) step();
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("wu_stop_busy", int'(bus.busy), 0);
    check("wu_stop_outs", int'({bus.codec_rst_n, bus.bclk, bus.lrclk, bus.bit_cnt}), 0);
    repeat (20) step();
    check("wu_stop_no_en", n_en, 0);

    // Simultaneous start and stop in IDLE.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("start_stop_busy", int'(bus.busy), 0);
    clr();
    repeat (30) step();
    check("start_stop_rstn", n_rstnhi, 0);
    check("start_stop_idle", int'(bus.busy), 0);

    // Async reset mid-RUN, then the power-up timing again.
    start_seq("s6a");
    repeat (100) step();
    check("pre_rst_busy", int'(bus.busy), 1);
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", int'({bus.codec_rst_n, bus.bclk, bus.lrclk, bus.en,
                                        bus.frame_start, bus.busy, bus.bit_cnt}), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    start_seq("s6b");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2s_clk_ctrl.md
Name: i2s_clk_ctrl

Overview:
- Master-mode clock sequencer for the I2S ADC receive path.
- Generates bclk and lrclk for the codec from the 100 MHz system clock.
- Sequences codec reset, clock warm-up and graceful stop.
- Issues the one-cycle en strobe that tells the i2s receiver when to sample sdi; en is delivered only while capture is active.

Parameters:
- BCLK_HALF, 2: clk cycles per bclk half-period; bclk = clk / (2*BCLK_HALF). Must be ≥1.
- FRAME_BITS, 64: bclk periods per lrclk frame. Power of 2, ≥16. lrclk is low for the first half (left) and high for the second half (right).
- RST_CYCLES, 16: clk cycles codec_rst_n is held low after start. Must be ≥1.
- WARMUP_FRAMES, 2: complete frames clocked with en masked before RUN. Must be ≥1.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-clk request to begin capture.
- stop  in  1  one-clk request to end capture.
- codec_rst_n  out  1  codec reset, active low.
- bclk  out  1  bit clock to codec and receiver.
- lrclk  out  1  word-select: 0 = left, 1 = right.
- en  out  1  one-clk sample strobe to receiver.
- frame_start  out  1  one-clk pulse at each frame boundary during RUN.
- busy  out  1  high in any state except IDLE.
- bit_cnt  out  $clog2(FRAME_BITS)  current bit position in frame.

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high. All outputs are registered and reset to 0: codec_rst_n=0, bclk=0, lrclk=0, en=0, frame_start=0, busy=0, bit_cnt=0. State resets to IDLE and the internal divider to 0.
- States: IDLE, CODEC_RST, WARMUP, RUN, DRAIN.
- IDLE:
  - bclk=0, lrclk=0, codec_rst_n=0, divider=0, bit_cnt=0.
  - start=1 and stop=0 → CODEC_RST.
  - start and stop both high → stop wins; remain in IDLE.
- CODEC_RST:
  - codec_rst_n=0; clocks held low.
  - After RST_CYCLES clk cycles in this state, codec_rst_n←1 and → WARMUP.
- Clock generator (active in WARMUP, RUN, DRAIN):
  - Divider counts 0..BCLK_HALF-1. On terminal count, bclk toggles and the divider wraps to 0.
  - First bclk rise occurs BCLK_HALF clks after codec_rst_n rises.
  - On each bclk falling toggle, bit_cnt increments modulo FRAME_BITS.
  - On each bclk falling toggle, lrclk ← (new bit_cnt ≥ FRAME_BITS/2). lrclk therefore changes only coincident with bclk falling.
  - A frame ends when bit_cnt wraps FRAME_BITS-1 → 0.
- WARMUP:
  - en masked.
  - After WARMUP_FRAMES frame ends → RUN. The transition happens in the same clk as the wrap.
- RUN:
  - en=1 for exactly the clk in which bclk is registered 0→1, i.e. coincident with the rising edge.
  - frame_start=1 in the clk where bit_cnt wraps to 0.
  - stop → DRAIN.
- DRAIN:
  - Identical to RUN, including en and frame_start, until the next frame end.
  - At that frame end → IDLE. bclk is already 0 at a falling toggle; lrclk←0.
  - Clocks freeze low from the next clk. The final right channel is thus always completed.
- stop in CODEC_RST or WARMUP → IDLE next clk with all outputs at reset values. A partial frame is abandoned.
- start while busy → ignored.
- stop in IDLE or DRAIN → ignored.
- rst asserted mid-operation → all outputs return to reset values immediately (asynchronous); no drain.
- Frame period = 2*BCLK_HALF*FRAME_BITS clk; 256 clk at defaults.
- en rate = one per bclk period; 4 clk at defaults.

Test Plan:
1. Reset, then start pulse sampled at edge k → codec_rst_n rises at k+16; first bclk rise at k+18; no en before k+530; first en at k+530; busy=1 from k+1.
2. Steady RUN at defaults → bclk period 4 clk (50% duty); lrclk period 256 clk, low for bit_cnt 0–31 and high for 32–63; lrclk transitions only in clks where bclk falls; exactly 64 en pulses and one frame_start per frame.
3. stop mid-frame in RUN at bit_cnt=40 → en continues through bit_cnt=63; IDLE at wrap with bclk=0, lrclk=0, codec_rst_n=0, busy=0; no further bclk edges.
4. stop during CODEC_RST (cycle k+5) and, separately, during WARMUP → IDLE next clk; en never asserted; codec_rst_n=0.
5. Simultaneous start and stop in IDLE → stays IDLE. A second start during RUN → no state change and no glitch in the bclk period.
6. Async rst asserted mid-RUN between clk edges → all outputs 0 immediately. After release, a fresh start repeats the timing of scenario 1 exactly.
